// File: rtl/inst_rom_loader_pkg.sv
// ----------------------------------------------------------------------------
// inst_rom_loader_pkg
//   Shared widths and loader FSM encodings for the instruction ROM loader.
//   INST_W   : instruction / register bus width
//   BYTE_W   : boot stream byte width
//   LD_*     : loader state encodings (HDR = collecting header, DATA =
//              collecting program words, RUN = image complete)
// ----------------------------------------------------------------------------
package inst_rom_loader_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [1:0]        ld_state_t;

  localparam ld_state_t LD_HDR  = 2'd0;
  localparam ld_state_t LD_DATA = 2'd1;
  localparam ld_state_t LD_RUN  = 2'd2;

  // Append one byte to the low end of a big-endian word under construction.
  function automatic inst_t shift_in_byte(input logic [23:0] upper, input byte_t b);
    return {upper, b};
  endfunction

endpackage

// File: rtl/inst_rom_loader_word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
//   Assembles a big-endian 32-bit word from a byte stream, MSB first.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   clear_i      : restart packing at byte 0 (takes priority over a byte)
//   byte_valid_i : a byte is transferred this cycle
//   byte_i       : the transferred byte
//   word_valid_o : this byte completes a word (combinational, same cycle)
//   word_o       : the completed word (meaningful with word_valid_o)
// ----------------------------------------------------------------------------
module word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear_i,
  input  logic  byte_valid_i,
  input  byte_t byte_i,
  output logic  word_valid_o,
  output inst_t word_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      byte_cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      shift_d    = {shift_q[15:0], byte_i};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      byte_cnt_q <= 2'd0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // The fourth byte is presented straight through so the word can be
  // written to RAM on the same edge that accepts it.
  assign word_valid_o = byte_valid_i & ~clear_i & (byte_cnt_q == 2'd3);
  assign word_o       = shift_in_byte(shift_q, byte_i);

endmodule

// File: rtl/inst_rom_loader.sv
// ----------------------------------------------------------------------------
// inst_rom_loader
//   Instruction memory on the far side of the CPU fetch port, filled at boot
//   from a byte stream: 4-byte big-endian word count N, then N big-endian
//   words. boot_done releases the CPU once the image is complete.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   ce_in      : fetch enable
//   addr_in    : fetch byte address
//   inst_out   : fetched word, 0 (nop) when disabled or outside the image
//   load_start : restart the boot load from any state
//   load_valid : load_byte valid
//   load_byte  : boot stream byte
//   load_ready : loader accepts load_byte this cycle
//   boot_done  : image complete
//   word_count : words stored by the last load (saturates at depth)
// ----------------------------------------------------------------------------
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_in,
  input  logic [31:0]         addr_in,
  output inst_t               inst_out,
  input  logic                load_start,
  input  logic                load_valid,
  input  byte_t               load_byte,
  output logic                load_ready,
  output logic                boot_done,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  ld_state_t           state_q, state_d;
  logic [31:0]         remain_q, remain_d;
  logic [ADDR_WIDTH:0] word_count_q, word_count_d;
  logic                ready_q, ready_d;
  logic                boot_done_q, boot_done_d;

  logic  accept;
  logic  word_valid;
  inst_t word;
  logic  wr_en;

  inst_t mem [2**ADDR_WIDTH];

  // A byte offered alongside load_start is dropped; ready is masked to match.
  assign accept = load_valid & ready_q & ~load_start;

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (load_start),
    .byte_valid_i (accept),
    .byte_i       (load_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Words past the RAM depth are still consumed so the stream stays in step.
  assign wr_en = (state_q == LD_DATA) & word_valid & (word_count_q < DEPTH_C);

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    word_count_d = word_count_q;
    if (load_start) begin
      state_d      = LD_HDR;
      remain_d     = '0;
      word_count_d = '0;
    end else begin
      case (state_q)
        LD_HDR: begin
          if (word_valid) begin
            remain_d = word;
            state_d  = (word == '0) ? LD_RUN : LD_DATA;
          end
        end
        LD_DATA: begin
          if (word_valid) begin
            remain_d = remain_q - 32'd1;
            if (wr_en) begin
              word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
            end
            if (remain_q == 32'd1) begin
              state_d = LD_RUN;
            end
          end
        end
        LD_RUN:  state_d = LD_RUN;
        default: state_d = LD_HDR;
      endcase
    end
    ready_d     = (state_d != LD_RUN);
    boot_done_d = (state_q == LD_RUN) & ~load_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LD_HDR;
      remain_q     <= '0;
      word_count_q <= '0;
      ready_q      <= 1'b0;
      boot_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      word_count_q <= word_count_d;
      ready_q      <= ready_d;
      boot_done_q  <= boot_done_d;
    end
  end

  // Program RAM: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_count_q[ADDR_WIDTH-1:0]] <= word;
    end
  end

  // Fetch path. floor(off/4) >= word_count is the same test as
  // off >= 4*word_count, which avoids discarding the low address bits.
  logic [31:0] off;
  logic        below_base;
  logic        past_end;

  assign off        = addr_in - BASE_ADDR;
  assign below_base = (addr_in < BASE_ADDR);
  assign past_end   = ({2'b00, off} >= 34'({word_count_q, 2'b00}));
  assign inst_out   = (!ce_in || below_base || past_end) ? '0
                                                         : mem[off[ADDR_WIDTH+1:2]];

  assign load_ready = ready_q & ~load_start;
  assign boot_done  = boot_done_q;
  assign word_count = word_count_q;

endmodule
